// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
package pwm_pkg;

   localparam logic MODE_EDGE   = 1'b0;
   localparam logic MODE_CENTER = 1'b1;

   localparam int unsigned PWM_DEF_WIDTH    = 16;
   localparam int unsigned PWM_DEF_CHANNELS = 4;

   // $clog2 that never returns less than 1, so a select port always has a bit.
   function automatic int unsigned pwm_clog2_min1(input int unsigned n);
      int unsigned w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: up or up/down counter, cycle boundary detect,
// enable handling and zero-period guard.
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int unsigned WIDTH = PWM_DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_enable,
   input  logic             i_mode,
   input  logic [WIDTH-1:0] i_period,
   output logic [WIDTH-1:0] o_counter,
   output logic             o_boundary_c,
   output logic             o_cycle_start_raw_c
);

   localparam int unsigned EW = WIDTH + 1;

   logic [WIDTH-1:0] r_cnt;
   logic             r_dir_down;
   logic [WIDTH-1:0] w_cnt_nxt;
   logic             w_dir_nxt;
   logic             w_boundary;
   logic             w_p_zero;
   logic             w_last;

   assign w_p_zero = (i_period == '0);
   // counter has reached P-1 (or beyond); evaluated wide so P-1 never underflows
   assign w_last   = (({1'b0, r_cnt} + EW'(1)) >= {1'b0, i_period});

   // Counter and direction state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_dir_down <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_dir_down <= w_dir_nxt;
      end
   end

   // Next counter/direction and boundary flag; idle and P=0 load shadows every clock.
   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_dir_nxt  = r_dir_down;
      w_boundary = 1'b0;
      if (!i_enable || w_p_zero) begin
         w_cnt_nxt  = '0;
         w_dir_nxt  = 1'b0;
         w_boundary = 1'b1;
      end else if (i_mode == MODE_EDGE) begin
         w_dir_nxt = 1'b0;
         if (w_last) begin
            w_cnt_nxt  = '0;
            w_boundary = 1'b1;
         end else begin
            w_cnt_nxt = r_cnt + WIDTH'(1);
         end
      end else if (!r_dir_down) begin
         // top of the triangle: hold the count one extra clock and turn around
         if (w_last) begin
            w_dir_nxt = 1'b1;
         end else begin
            w_cnt_nxt = r_cnt + WIDTH'(1);
         end
      end else begin
         // bottom of the triangle: hold zero one extra clock, this is the boundary
         if (r_cnt == '0) begin
            w_dir_nxt  = 1'b0;
            w_boundary = 1'b1;
         end else begin
            w_cnt_nxt = r_cnt - WIDTH'(1);
         end
      end
   end

   assign o_counter           = r_cnt;
   assign o_boundary_c        = w_boundary;
   assign o_cycle_start_raw_c = i_enable && !w_p_zero && (r_cnt == '0) && !r_dir_down;

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator with shadowed period/mode/duty registers that
// apply only at cycle boundaries. Edge- and center-aligned modes.
// Optional PWM_POLARITY_EN adds a per-channel output polarity / idle level.
module pwm_multi_channel
   import pwm_pkg::*;
#(
   parameter int unsigned WIDTH    = PWM_DEF_WIDTH,
   parameter int unsigned CHANNELS = PWM_DEF_CHANNELS,
   parameter int unsigned CH_W     = pwm_clog2_min1(CHANNELS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                center_mode_in,
   input  logic [WIDTH-1:0]    period_in,
   input  logic                period_wr,
   input  logic                duty_wr,
   input  logic [CH_W-1:0]     duty_ch,
   input  logic [WIDTH-1:0]    duty_in,
`ifdef PWM_POLARITY_EN
   input  logic [CHANNELS-1:0] polarity,
`endif
   output logic [CHANNELS-1:0] pwm_out,
   output logic                cycle_start,
   output logic                update_pending
);

   logic [WIDTH-1:0]    r_period_sh;
   logic                r_mode_sh;
   logic [WIDTH-1:0]    r_period_act;
   logic                r_mode_act;
   logic [CHANNELS-1:0] r_pwm;
   logic                r_cycle_start;
   logic                r_pending;

   logic [WIDTH-1:0]    w_counter;
   logic                w_boundary_c;
   logic                w_cs_raw_c;
   logic [CHANNELS-1:0] w_raw;
   logic [CHANNELS-1:0] w_pol;
   logic                w_ch_valid;
   logic                w_wr_accept;
   logic                w_p_nonzero;

`ifdef PWM_POLARITY_EN
   assign w_pol = polarity;
`else
   assign w_pol = '0;
`endif

   assign w_ch_valid  = (32'(duty_ch) < CHANNELS);
   assign w_wr_accept = period_wr || (duty_wr && w_ch_valid);
   assign w_p_nonzero = (r_period_act != '0);

   pwm_timebase #(
      .WIDTH (WIDTH)
   ) u_timebase (
      .clk                 (clk),
      .rst_n               (rst_n),
      .i_enable            (enable),
      .i_mode              (r_mode_act),
      .i_period            (r_period_act),
      .o_counter           (w_counter),
      .o_boundary_c        (w_boundary_c),
      .o_cycle_start_raw_c (w_cs_raw_c)
   );

   // Period/mode shadow and active registers; active follows shadow at a boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_period_sh  <= '0;
         r_mode_sh    <= MODE_EDGE;
         r_period_act <= '0;
         r_mode_act   <= MODE_EDGE;
      end else begin
         if (period_wr) begin
            r_period_sh <= period_in;
            r_mode_sh   <= center_mode_in;
         end
         if (w_boundary_c) begin
            r_period_act <= r_period_sh;
            r_mode_act   <= r_mode_sh;
         end
      end
   end

   for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
      logic [WIDTH-1:0] r_duty_sh;
      logic [WIDTH-1:0] r_duty_act;
      logic [WIDTH:0]   w_sum;

      // Per-channel duty shadow and active register.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_duty_sh  <= '0;
            r_duty_act <= '0;
         end else begin
            if (duty_wr && (duty_ch == CH_W'(i))) begin
               r_duty_sh <= duty_in;
            end
            if (w_boundary_c) begin
               r_duty_act <= r_duty_sh;
            end
         end
      end

      // center compare counter >= P-D rewritten as counter+D >= P to stay unsigned
      assign w_sum    = {1'b0, w_counter} + {1'b0, r_duty_act};
      assign w_raw[i] = w_p_nonzero &&
                        ((r_mode_act == MODE_CENTER) ? (w_sum >= {1'b0, r_period_act})
                                                     : ({1'b0, w_counter} < {1'b0, r_duty_act}));
   end

   // Output registers: PWM level, cycle-start pulse and pending-update flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwm         <= '0;
         r_cycle_start <= 1'b0;
         r_pending     <= 1'b0;
      end else begin
         r_cycle_start <= w_cs_raw_c;
         r_pwm         <= enable ? (w_raw ^ w_pol) : w_pol;
         if (!enable) begin
            r_pending <= 1'b0;
         end else if (w_wr_accept) begin
            r_pending <= 1'b1;
         end else if (w_boundary_c) begin
            r_pending <= 1'b0;
         end
      end
   end

   assign pwm_out        = r_pwm;
   assign cycle_start    = r_cycle_start;
   assign update_pending = r_pending;

endmodule
